// File: rtl/dmem_arbiter_if.sv
// Bus bundle between two data-memory requesters, the arbiter and a single-port memory.
// Handshake: a port's request is taken in the cycle where req & gnt are both 1; gnt is combinational and never held across cycles.
interface dmem_arbiter_if;
    logic        req0_i;
    logic        req1_i;
    logic        we0_i;
    logic        we1_i;
    logic [31:0] adr0_i;
    logic [31:0] adr1_i;
    logic [31:0] wdata0_i;
    logic [31:0] wdata1_i;
    logic        gnt0_o;
    logic        gnt1_o;
    logic        rvalid0_o;
    logic        rvalid1_o;
    logic [31:0] rdata0_o;
    logic [31:0] rdata1_o;
    logic        err0_o;
    logic        err1_o;
    logic        MemWr_o;
    logic        MemRe_o;
    logic [31:0] Adr_o;
    logic [31:0] mdata_o;
    logic [31:0] mdata_i;

    modport slave (
        input  req0_i, req1_i, we0_i, we1_i, adr0_i, adr1_i, wdata0_i, wdata1_i, mdata_i,
        output gnt0_o, gnt1_o, rvalid0_o, rvalid1_o, rdata0_o, rdata1_o, err0_o, err1_o,
               MemWr_o, MemRe_o, Adr_o, mdata_o
    );

    modport master (
        output req0_i, req1_i, we0_i, we1_i, adr0_i, adr1_i, wdata0_i, wdata1_i, mdata_i,
        input  gnt0_o, gnt1_o, rvalid0_o, rvalid1_o, rdata0_o, rdata1_o, err0_o, err1_o,
               MemWr_o, MemRe_o, Adr_o, mdata_o
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port data memory with 1-cycle read latency.
// Optional address checking is enabled by defining DMEM_ARB_ADDR_CHECK_EN.
module dmem_arbiter #(
    parameter int unsigned ADDR_MAX = 28
) (
    input  logic           clk_i,
    input  logic           rst_i,
    dmem_arbiter_if.slave  bus,
    output logic           dbg_state
);

`ifdef DMEM_ARB_ADDR_CHECK_EN
    localparam bit ADDR_CHECK = 1'b1;
`else
    localparam bit ADDR_CHECK = 1'b0;
`endif

    typedef enum logic {
        IDLE   = 1'b0,
        RD_RSP = 1'b1
    } state_t;

    state_t      state;
    logic        last1;
    logic        gnt0;
    logic        gnt1;
    logic        acc;
    logic        legal;
    logic        mem_en;
    logic        sel_we;
    logic [31:0] sel_adr;
    logic [31:0] sel_wdata;
    logic        rvalid0;
    logic        rvalid1;
    logic        err0;
    logic        err1;
    logic [31:0] rdata0_q;
    logic [31:0] rdata1_q;

    // Port 0 wins unless port 1 also asks and port 0 was the last one served.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst_i) begin
            if (bus.req0_i && (!bus.req1_i || last1)) begin
                gnt0 = 1'b1;
            end else if (bus.req1_i) begin
                gnt1 = 1'b1;
            end
        end
    end

    always_comb begin
        sel_we    = bus.we0_i;
        sel_adr   = bus.adr0_i;
        sel_wdata = bus.wdata0_i;
        if (gnt1) begin
            sel_we    = bus.we1_i;
            sel_adr   = bus.adr1_i;
            sel_wdata = bus.wdata1_i;
        end
    end

    assign acc    = gnt0 | gnt1;
    assign legal  = !ADDR_CHECK || ((sel_adr <= ADDR_MAX) && (sel_adr[1:0] == 2'b00));
    assign mem_en = acc && legal;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state    <= IDLE;
            last1    <= 1'b1;
            rvalid0  <= 1'b0;
            rvalid1  <= 1'b0;
            err0     <= 1'b0;
            err1     <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            if (acc) begin
                last1 <= gnt1;
            end
            state   <= (mem_en && !sel_we) ? RD_RSP : IDLE;
            rvalid0 <= mem_en && !sel_we && gnt0;
            rvalid1 <= mem_en && !sel_we && gnt1;
            err0    <= gnt0 && !legal;
            err1    <= gnt1 && !legal;
            // Memory data is only valid in the response cycle, so capture it there for holding.
            if (rvalid0) begin
                rdata0_q <= bus.mdata_i;
            end
            if (rvalid1) begin
                rdata1_q <= bus.mdata_i;
            end
        end
    end

    assign bus.gnt0_o    = gnt0;
    assign bus.gnt1_o    = gnt1;
    assign bus.MemWr_o   = mem_en && sel_we;
    assign bus.MemRe_o   = mem_en && !sel_we;
    assign bus.Adr_o     = mem_en ? sel_adr : 32'd0;
    assign bus.mdata_o   = mem_en ? sel_wdata : 32'd0;
    assign bus.rvalid0_o = rvalid0;
    assign bus.rvalid1_o = rvalid1;
    assign bus.rdata0_o  = rvalid0 ? bus.mdata_i : rdata0_q;
    assign bus.rdata1_o  = rvalid1 ? bus.mdata_i : rdata1_q;
    assign bus.err0_o    = err0;
    assign bus.err1_o    = err1;
    assign dbg_state     = state;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a cycle-level reference model checks every output each cycle,
// while directed sequences pin key cycles against hand-computed literals.
module tb_dmem_arbiter;

`ifdef DMEM_ARB_ADDR_CHECK_EN
    localparam bit CHECK_ON = 1'b1;
`else
    localparam bit CHECK_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_i;
    logic dbg_state;

    dmem_arbiter_if bus ();

    dmem_arbiter #(.ADDR_MAX(28)) dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Memory model driving mdata_i; garbage when no read so held rdata is exercised.
    logic [31:0] mem [8];
    always @(posedge clk) begin
        if (bus.MemWr_o) mem[bus.Adr_o[4:2]] <= bus.mdata_o;
        bus.mdata_i <= bus.MemRe_o ? mem[bus.Adr_o[4:2]] : $urandom;
    end

    // Reference model state: memory shadow, last-served port, pending read, pending errors.
    logic [31:0] ref_mem [8];
    int          m_last;
    bit          m_pend;
    int          m_pend_port;
    logic [31:0] m_pend_data;
    bit          m_err [2];
    logic [31:0] m_hold [2];
    bit          e_g0, e_g1, e_acc, e_ok, a_we;
    int          a_port, idx;
    logic [31:0] a_adr, a_wd;

    function automatic bit addr_ok(input logic [31:0] a);
        return !CHECK_ON || ((a <= 32'd28) && (a % 4 == 0));
    endfunction

    always @(negedge clk) begin
        if (!rst_i) begin
            chk("m_gnt0", bus.gnt0_o, 0);       chk("m_gnt1", bus.gnt1_o, 0);
            chk("m_rvalid0", bus.rvalid0_o, 0); chk("m_rvalid1", bus.rvalid1_o, 0);
            chk("m_err0", bus.err0_o, 0);       chk("m_err1", bus.err1_o, 0);
            chk("m_memwr", bus.MemWr_o, 0);     chk("m_memre", bus.MemRe_o, 0);
            chk("m_adr", bus.Adr_o, 0);         chk("m_mdata", bus.mdata_o, 0);
            chk("m_rdata0", bus.rdata0_o, 0);   chk("m_rdata1", bus.rdata1_o, 0);
            m_last = 1; m_pend = 0; m_err = '{0, 0}; m_hold = '{32'd0, 32'd0};
        end else begin
            e_g0   = bus.req0_i && (!bus.req1_i || m_last == 1);
            e_g1   = bus.req1_i && !e_g0;
            e_acc  = e_g0 || e_g1;
            a_port = e_g1 ? 1 : 0;
            a_we   = e_g1 ? bus.we1_i : bus.we0_i;
            a_adr  = e_g1 ? bus.adr1_i : bus.adr0_i;
            a_wd   = e_g1 ? bus.wdata1_i : bus.wdata0_i;
            e_ok   = e_acc && addr_ok(a_adr);
            chk("m_gnt0", bus.gnt0_o, e_g0);
            chk("m_gnt1", bus.gnt1_o, e_g1);
            chk("m_memwr", bus.MemWr_o, e_ok && a_we);
            chk("m_memre", bus.MemRe_o, e_ok && !a_we);
            chk("m_adr", bus.Adr_o, e_ok ? a_adr : 32'd0);
            chk("m_mdata", bus.mdata_o, e_ok ? a_wd : 32'd0);
            chk("m_rvalid0", bus.rvalid0_o, m_pend && m_pend_port == 0);
            chk("m_rvalid1", bus.rvalid1_o, m_pend && m_pend_port == 1);
            if (m_pend) m_hold[m_pend_port] = m_pend_data;
            chk("m_rdata0", bus.rdata0_o, m_hold[0]);
            chk("m_rdata1", bus.rdata1_o, m_hold[1]);
            chk("m_err0", bus.err0_o, m_err[0]);
            chk("m_err1", bus.err1_o, m_err[1]);
            idx = int'((a_adr / 4) % 8);
            m_err[0]    = e_g0 && !addr_ok(a_adr);
            m_err[1]    = e_g1 && !addr_ok(a_adr);
            m_pend      = e_ok && !a_we;
            m_pend_port = a_port;
            m_pend_data = ref_mem[idx];
            if (e_ok && a_we) ref_mem[idx] = a_wd;
            if (e_acc) m_last = a_port;
        end
    end

    task automatic drive(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                         input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1);
        bus.req0_i = r0; bus.we0_i = w0; bus.adr0_i = a0; bus.wdata0_i = d0;
        bus.req1_i = r1; bus.we1_i = w1; bus.adr1_i = a1; bus.wdata1_i = d1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 8; i++) begin
            mem[i]     = 32'hA5A5_0000 + i;
            ref_mem[i] = 32'hA5A5_0000 + i;
        end
        rst_i = 1'b0;
        // Requests during reset must not be granted.
        drive(1, 0, 0, 0, 1, 0, 4, 0);
        repeat (3) begin
            @(negedge clk);
            chk("rst_gnt0", bus.gnt0_o, 0);
            chk("rst_gnt1", bus.gnt1_o, 0);
        end
        step();
        rst_i = 1'b1;

        // Both reads held 4 cycles: port 0 first, then alternate; responses one cycle behind.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rr_gnt0", bus.gnt0_o, (k % 2) == 0);
            chk("rr_gnt1", bus.gnt1_o, (k % 2) == 1);
            chk("rr_rvalid0", bus.rvalid0_o, (k % 2) == 1);
            chk("rr_rvalid1", bus.rvalid1_o, k > 0 && (k % 2) == 0);
            step();
        end
        idle();
        @(negedge clk);
        chk("rr_last_rvalid1", bus.rvalid1_o, 1);
        chk("rr_last_rdata1", bus.rdata1_o, 32'hA5A5_0001);
        step();

        // Write then read the same word from port 0.
        drive(1, 1, 8, 32'hDEADBEEF, 0, 0, 0, 0);
        @(negedge clk);
        chk("wr_memwr", bus.MemWr_o, 1);
        chk("wr_adr", bus.Adr_o, 8);
        chk("wr_mdata", bus.mdata_o, 32'hDEADBEEF);
        step();
        drive(1, 0, 8, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("rd_memre", bus.MemRe_o, 1);
        chk("rd_memwr", bus.MemWr_o, 0);
        step();
        idle();
        @(negedge clk);
        chk("rd_rvalid0", bus.rvalid0_o, 1);
        chk("rd_rdata0", bus.rdata0_o, 32'hDEADBEEF);
        step();
        @(negedge clk);
        chk("hold_rvalid0", bus.rvalid0_o, 0);
        chk("hold_rdata0", bus.rdata0_o, 32'hDEADBEEF);
        step();

        // Back-to-back reads 0,4,8 after filling words 0 (port 0) and 4 (port 1 alone).
        drive(1, 1, 0, 32'h1111_0000, 0, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 1, 1, 4, 32'h2222_0004);
        @(negedge clk);
        chk("solo_gnt1", bus.gnt1_o, 1);
        step();
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        step();
        drive(1, 0, 4, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("b2b_rdata_a", bus.rdata0_o, 32'h1111_0000);
        chk("b2b_gnt_b", bus.gnt0_o, 1);
        step();
        drive(1, 0, 8, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("b2b_rdata_b", bus.rdata0_o, 32'h2222_0004);
        step();
        idle();
        @(negedge clk);
        chk("b2b_rvalid_c", bus.rvalid0_o, 1);
        chk("b2b_rdata_c", bus.rdata0_o, 32'hDEADBEEF);
        step();

        // Mixed directed vectors, checked by the model.
        drive(1, 1, 12, 32'hC0DE_0012, 1, 0, 12, 0);  step();
        drive(1, 1, 12, 32'hC0DE_0012, 1, 0, 16, 0);  step();
        drive(0, 0, 0, 0, 1, 0, 12, 0);               step();
        drive(1, 0, 20, 0, 1, 1, 20, 32'h5555_0020);  step();
        idle();                                       step();
        drive(0, 0, 0, 0, 1, 1, 28, 32'h7777_0028);   step();
        drive(1, 0, 30, 0, 1, 0, 24, 0);              step();
        drive(1, 0, 28, 0, 1, 0, 24, 0);              step();
        idle();                                       step();

`ifdef DMEM_ARB_ADDR_CHECK_EN
        for (int j = 0; j < 2; j++) begin
            drive(1, 0, (j == 0) ? 32'd32 : 32'd6, 0, 0, 0, 0, 0);
            @(negedge clk);
            chk("bad_gnt0", bus.gnt0_o, 1);
            chk("bad_memre", bus.MemRe_o, 0);
            step();
            idle();
            @(negedge clk);
            chk("bad_err0", bus.err0_o, 1);
            chk("bad_rvalid0", bus.rvalid0_o, 0);
            step();
        end
`else
        drive(1, 0, 36, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("nochk_memre", bus.MemRe_o, 1);
        chk("nochk_adr", bus.Adr_o, 36);
        step();
        idle();
        @(negedge clk);
        chk("nochk_err0", bus.err0_o, 0);
        chk("nochk_rvalid0", bus.rvalid0_o, 1);
        step();
`endif

        // Reset with a port-1 read in flight discards the response.
        drive(0, 0, 0, 0, 1, 0, 4, 0);
        @(negedge clk);
        chk("inflight_gnt1", bus.gnt1_o, 1);
        step();
        rst_i = 1'b0;
        idle();
        repeat (2) begin
            @(negedge clk);
            chk("rstmid_rvalid1", bus.rvalid1_o, 0);
            chk("rstmid_rdata1", bus.rdata1_o, 0);
            chk("rstmid_adr", bus.Adr_o, 0);
            step();
        end
        rst_i = 1'b1;
        @(negedge clk);
        chk("post_rvalid1", bus.rvalid1_o, 0);
        step();
        drive(1, 0, 0, 0, 1, 0, 4, 0);
        @(negedge clk);
        chk("post_gnt0", bus.gnt0_o, 1);
        step();
        idle();
        repeat (2) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
